// File: rtl/sprite_sequencer.sv
// Tick-driven sprite animation sequencer: steps a frame index through loop,
// ping-pong or one-shot playback and registers the matching sprite ROM offset.
module sprite_sequencer #(
  parameter int NUM_FRAMES = 8,
  parameter int HOLD_W     = 4,
  parameter int DIM_W      = 10,
  parameter int OFS_W      = 32,
  localparam int FC_W      = $clog2(NUM_FRAMES + 1)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              tick,
  input  logic              moving,
  input  logic [1:0]        mode,
  input  logic [FC_W-1:0]   frame_count,
  input  logic [HOLD_W-1:0] hold,
  input  logic [DIM_W-1:0]  sprite_height,
  input  logic [DIM_W-1:0]  sprite_width,
  input  logic [OFS_W-1:0]  base_offset,
  output logic [OFS_W-1:0]  animation_offset,
  output logic [FC_W-1:0]   frame_idx,
  output logic              done,
  output logic              wrap
);

  localparam int PW = FC_W + 2 * DIM_W;
  localparam logic [FC_W-1:0]   IDX_ZERO  = {FC_W{1'b0}};
  localparam logic [FC_W-1:0]   IDX_ONE   = FC_W'(1'b1);
  localparam logic [FC_W-1:0]   IDX_TWO   = FC_W'(2'd2);
  localparam logic [FC_W-1:0]   IDX_MAX   = FC_W'(NUM_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
  localparam logic [1:0]        MODE_PP   = 2'b01;
  localparam logic [1:0]        MODE_ONE  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r, state_nx_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nx_s;
  logic [HOLD_W-1:0] hold_r, hold_nx_s;
  logic [FC_W-1:0]   n_r, n_nx_s, n_clamp_s;
  logic [1:0]        mode_r, mode_nx_s;
  logic              dir_down_r, dir_down_nx_s;
  logic [FC_W-1:0]   idx_nx_s;
  logic              wrap_nx_s;
  logic [PW-1:0]     prod_s;
  logic [OFS_W-1:0]  offset_nx_s;

  // Clamp the requested run length into 1..NUM_FRAMES before latching it
  always_comb begin
    n_clamp_s = frame_count;
    if (frame_count == IDX_ZERO) begin
      n_clamp_s = IDX_ONE;
    end else if (frame_count > IDX_MAX) begin
      n_clamp_s = IDX_MAX;
    end else begin
      n_clamp_s = frame_count;
    end
  end

  // Offset from the current index and live dimensions, full-width product
  always_comb begin
    prod_s      = PW'(frame_idx) * PW'(sprite_height) * PW'(sprite_width);
    offset_nx_s = base_offset + OFS_W'(prod_s);
  end

  // Next-state, index, hold counter and wrap decode; nothing moves without tick
  always_comb begin
    state_nx_s    = state_r;
    idx_nx_s      = frame_idx;
    hold_cnt_nx_s = hold_cnt_r;
    dir_down_nx_s = dir_down_r;
    mode_nx_s     = mode_r;
    n_nx_s        = n_r;
    hold_nx_s     = hold_r;
    wrap_nx_s     = 1'b0;
    if (tick) begin
      case (state_r)
        IDLE: begin
          idx_nx_s      = IDX_ZERO;
          hold_cnt_nx_s = HOLD_ZERO;
          dir_down_nx_s = 1'b0;
          if (moving) begin
            state_nx_s = RUN;
            mode_nx_s  = mode;
            n_nx_s     = n_clamp_s;
            hold_nx_s  = hold;
            idx_nx_s   = IDX_ONE;
          end else begin
            state_nx_s = IDLE;
          end
        end
        RUN: begin
          if (!moving) begin
            state_nx_s    = IDLE;
            idx_nx_s      = IDX_ZERO;
            hold_cnt_nx_s = HOLD_ZERO;
            dir_down_nx_s = 1'b0;
          end else if (hold_cnt_r < hold_r) begin
            hold_cnt_nx_s = hold_cnt_r + HOLD_ONE;
          end else begin
            hold_cnt_nx_s = HOLD_ZERO;
            case (mode_r)
              MODE_PP: begin
                // A single-frame ping-pong never turns around
                if (n_r == IDX_ONE) begin
                  idx_nx_s      = IDX_ONE;
                  dir_down_nx_s = 1'b0;
                  wrap_nx_s     = 1'b1;
                end else if (!dir_down_r) begin
                  if (frame_idx < n_r) begin
                    idx_nx_s = frame_idx + IDX_ONE;
                  end else begin
                    idx_nx_s      = n_r - IDX_ONE;
                    dir_down_nx_s = 1'b1;
                  end
                end else begin
                  if (frame_idx > IDX_ONE) begin
                    idx_nx_s = frame_idx - IDX_ONE;
                  end else begin
                    idx_nx_s      = IDX_TWO;
                    dir_down_nx_s = 1'b0;
                    wrap_nx_s     = 1'b1;
                  end
                end
              end
              MODE_ONE: begin
                if (frame_idx < n_r) begin
                  idx_nx_s = frame_idx + IDX_ONE;
                end else begin
                  state_nx_s = DONE;
                end
              end
              default: begin
                if (frame_idx < n_r) begin
                  idx_nx_s = frame_idx + IDX_ONE;
                end else begin
                  idx_nx_s  = IDX_ONE;
                  wrap_nx_s = 1'b1;
                end
              end
            endcase
          end
        end
        DONE: begin
          if (!moving) begin
            state_nx_s    = IDLE;
            idx_nx_s      = IDX_ZERO;
            hold_cnt_nx_s = HOLD_ZERO;
            dir_down_nx_s = 1'b0;
          end else begin
            state_nx_s = DONE;
          end
        end
        default: begin
          state_nx_s    = IDLE;
          idx_nx_s      = IDX_ZERO;
          hold_cnt_nx_s = HOLD_ZERO;
          dir_down_nx_s = 1'b0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r          <= IDLE;
      hold_cnt_r       <= HOLD_ZERO;
      hold_r           <= HOLD_ZERO;
      n_r              <= IDX_ONE;
      mode_r           <= 2'b00;
      dir_down_r       <= 1'b0;
      frame_idx        <= IDX_ZERO;
      done             <= 1'b0;
      wrap             <= 1'b0;
      animation_offset <= {OFS_W{1'b0}};
    end else begin
      state_r          <= state_nx_s;
      hold_cnt_r       <= hold_cnt_nx_s;
      hold_r           <= hold_nx_s;
      n_r              <= n_nx_s;
      mode_r           <= mode_nx_s;
      dir_down_r       <= dir_down_nx_s;
      frame_idx        <= idx_nx_s;
      done             <= (state_nx_s == DONE);
      wrap             <= wrap_nx_s;
      animation_offset <= offset_nx_s;
    end
  end

endmodule

// File: tb/tb_sprite_sequencer.sv
// Bench for sprite_sequencer: directed table, corner-case sequences and a
// randomized run checked against a frame-counting reference model.
module tb_sprite_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        tick;
  logic        moving;
  logic [1:0]  mode;
  logic [3:0]  frame_count;
  logic [3:0]  hold;
  logic [9:0]  sprite_height;
  logic [9:0]  sprite_width;
  logic [31:0] base_offset;
  logic [31:0] animation_offset;
  logic [3:0]  frame_idx;
  logic        done;
  logic        wrap;

  int n_vec = 0;
  int n_err = 0;

  sprite_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .tick(tick), .moving(moving), .mode(mode),
    .frame_count(frame_count), .hold(hold), .sprite_height(sprite_height),
    .sprite_width(sprite_width), .base_offset(base_offset),
    .animation_offset(animation_offset), .frame_idx(frame_idx),
    .done(done), .wrap(wrap)
  );

  always #5 Clk = ~Clk;

  // Reference model: frames are derived from an advance count k and hold ticks t
  int m_st = 0, m_k = 0, m_t = 0, m_mode = 0, m_n = 1, m_hold = 0, m_idx = 0;
  bit m_wrap = 1'b0, m_done = 1'b0;
  logic [31:0] m_off = 32'd0;

  function automatic int pp_idx(input int k, input int n);
    int per, p;
    per = (n == 1) ? 1 : 2 * n - 2;
    p = k % per;
    return (p < n) ? p + 1 : 2 * n - 1 - p;
  endfunction

  task automatic model_step();
    logic [63:0] prod;
    int per;
    prod = 64'(m_idx) * 64'(sprite_height) * 64'(sprite_width);
    if (!Reset_n) begin
      m_st = 0; m_idx = 0; m_k = 0; m_t = 0;
      m_wrap = 1'b0; m_done = 1'b0; m_off = 32'd0;
      return;
    end
    m_off  = base_offset + prod[31:0];
    m_wrap = 1'b0;
    if (tick) begin
      if (m_st == 0) begin
        if (moving) begin
          m_mode = int'(mode);
          m_n    = (frame_count == 4'd0) ? 1 : ((int'(frame_count) > 8) ? 8 : int'(frame_count));
          m_hold = int'(hold);
          m_st = 1; m_k = 0; m_t = 0; m_idx = 1;
        end
      end else if (!moving) begin
        m_st = 0; m_idx = 0;
      end else if (m_st == 1) begin
        if (m_t < m_hold) begin
          m_t++;
        end else begin
          m_t = 0;
          if (m_mode == 2 && m_k + 1 >= m_n) begin
            m_st = 2;
          end else begin
            m_k++;
            if (m_mode == 1) begin
              m_idx = pp_idx(m_k, m_n);
              per = (m_n == 1) ? 1 : 2 * m_n - 2;
              m_wrap = (m_n == 1) || (m_k > 1 && (m_k % per) == 1);
            end else if (m_mode == 2) begin
              m_idx = m_k + 1;
            end else begin
              m_idx  = (m_k % m_n) + 1;
              m_wrap = ((m_k % m_n) == 0);
            end
          end
        end
      end
    end
    m_done = (m_st == 2);
  endtask

  task automatic step();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".idx"},  32'(frame_idx), 32'(m_idx));
    chk({tag, ".wrap"}, 32'(wrap),      32'(m_wrap));
    chk({tag, ".done"}, 32'(done),      32'(m_done));
    chk({tag, ".off"},  animation_offset, m_off);
  endtask

  typedef struct {
    logic        rst_n, tk, mv;
    logic [1:0]  md;
    logic [3:0]  fc, hd;
    logic [31:0] base;
    logic [3:0]  e_idx;
    logic        e_wrap, e_done;
    logic [31:0] e_off;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic t, input logic mv,
                              input logic [1:0] md, input logic [3:0] fc,
                              input logic [3:0] hd, input logic [31:0] b,
                              input logic [3:0] ei, input logic ew,
                              input logic ed, input logic [31:0] eo);
    vec_t v;
    v.rst_n = r; v.tk = t; v.mv = mv; v.md = md; v.fc = fc; v.hd = hd; v.base = b;
    v.e_idx = ei; v.e_wrap = ew; v.e_done = ed; v.e_off = eo;
    return v;
  endfunction

  vec_t tbl [18];
  int pp_seq [10] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 2};

  initial begin
    Reset_n = 1'b0; tick = 1'b0; moving = 1'b0; mode = 2'b00;
    frame_count = 4'd3; hold = 4'd0; sprite_height = 10'd10; sprite_width = 10'd10;
    base_offset = 32'd0;

    // Loop N=3 walk, then one-shot N=2 hold=1 into DONE and back to IDLE
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 4'd3, 4'd0, 32'h0,    4'd0, 1'b0, 1'b0, 32'd0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 4'd3, 4'd0, 32'h0,    4'd0, 1'b0, 1'b0, 32'd0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b1, 2'd0, 4'd3, 4'd0, 32'h0,    4'd1, 1'b0, 1'b0, 32'd0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 2'd0, 4'd3, 4'd0, 32'h0,    4'd2, 1'b0, 1'b0, 32'd100);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 2'd0, 4'd3, 4'd0, 32'h0,    4'd3, 1'b0, 1'b0, 32'd200);
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, 2'd0, 4'd3, 4'd0, 32'h0,    4'd1, 1'b1, 1'b0, 32'd300);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 2'd0, 4'd3, 4'd0, 32'h0,    4'd2, 1'b0, 1'b0, 32'd100);
    tbl[7]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 4'd3, 4'd0, 32'h0,    4'd2, 1'b0, 1'b0, 32'd200);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 4'd3, 4'd0, 32'h0,    4'd0, 1'b0, 1'b0, 32'd200);
    tbl[9]  = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'd2, 4'd1, 32'h1000, 4'd1, 1'b0, 1'b0, 32'h1000);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'd2, 4'd1, 32'h1000, 4'd1, 1'b0, 1'b0, 32'h1064);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'd2, 4'd1, 32'h1000, 4'd2, 1'b0, 1'b0, 32'h1064);
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'd2, 4'd1, 32'h1000, 4'd2, 1'b0, 1'b0, 32'h10C8);
    tbl[13] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'd2, 4'd1, 32'h1000, 4'd2, 1'b0, 1'b1, 32'h10C8);
    tbl[14] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'd2, 4'd1, 32'h1000, 4'd2, 1'b0, 1'b1, 32'h10C8);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 2'd2, 4'd2, 4'd1, 32'h1000, 4'd2, 1'b0, 1'b1, 32'h10C8);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'd2, 4'd1, 32'h1000, 4'd0, 1'b0, 1'b0, 32'h10C8);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 2'd2, 4'd2, 4'd1, 32'h1000, 4'd0, 1'b0, 1'b0, 32'h1000);

    for (int i = 0; i < 18; i++) begin
      Reset_n = tbl[i].rst_n; tick = tbl[i].tk; moving = tbl[i].mv; mode = tbl[i].md;
      frame_count = tbl[i].fc; hold = tbl[i].hd; base_offset = tbl[i].base;
      step();
      chk($sformatf("tbl%0d.idx", i),  32'(frame_idx), 32'(tbl[i].e_idx));
      chk($sformatf("tbl%0d.wrap", i), 32'(wrap),      32'(tbl[i].e_wrap));
      chk($sformatf("tbl%0d.done", i), 32'(done),      32'(tbl[i].e_done));
      chk($sformatf("tbl%0d.off", i),  animation_offset, tbl[i].e_off);
    end

    // Ping-pong N=5 hold=3: 40 ticks, wrap only on the down-going 1->2
    tick = 1'b1; moving = 1'b1; mode = 2'b01; frame_count = 4'd5; hold = 4'd3;
    for (int i = 0; i < 40; i++) begin
      step();
      chk($sformatf("pp%0d.idx", i),  32'(frame_idx), 32'(pp_seq[i / 4]));
      chk($sformatf("pp%0d.wrap", i), 32'(wrap),      32'(i == 36));
    end

    // Drop moving mid-hold in loop N=4 hold=7, then restart with a fresh hold
    moving = 1'b0; step();
    chk("mvdrop.idle", 32'(frame_idx), 32'd0);
    moving = 1'b1; mode = 2'b00; frame_count = 4'd4; hold = 4'd7;
    step();
    for (int i = 0; i < 18; i++) step();
    chk("mvdrop.at3", 32'(frame_idx), 32'd3);
    moving = 1'b0; step();
    chk("mvdrop.idx0", 32'(frame_idx), 32'd0);
    moving = 1'b1; step();
    chk("mvdrop.restart", 32'(frame_idx), 32'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("mvdrop.hold%0d", i), 32'(frame_idx), 32'd1);
    end
    step();
    chk("mvdrop.adv", 32'(frame_idx), 32'd2);

    // Reset mid-run with tick low, then a clamped N=0 run that wraps every advance
    tick = 1'b0; Reset_n = 1'b0; base_offset = 32'h2000; step();
    chk("rst.idx",  32'(frame_idx), 32'd0);
    chk("rst.wrap", 32'(wrap),      32'd0);
    chk("rst.done", 32'(done),      32'd0);
    chk("rst.off",  animation_offset, 32'd0);
    Reset_n = 1'b1; step();
    chk("rst.base", animation_offset, 32'h2000);
    tick = 1'b1; moving = 1'b1; mode = 2'b00; frame_count = 4'd0; hold = 4'd0;
    step();
    chk("n0.entry", 32'(frame_idx), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("n0.%0d.idx", i),  32'(frame_idx), 32'd1);
      chk($sformatf("n0.%0d.wrap", i), 32'(wrap),      32'd1);
    end
    tick = 1'b0; step();
    chk("n0.wrapdrop", 32'(wrap), 32'd0);
    tick = 1'b1; Reset_n = 1'b0; step();
    chk("rst2.wrap", 32'(wrap),      32'd0);
    chk("rst2.idx",  32'(frame_idx), 32'd0);
    Reset_n = 1'b1;

    // frame_count changed mid-run must not move the wrap point
    mode = 2'b00; frame_count = 4'd3; hold = 4'd0; step();
    chk("fcchg.entry", 32'(frame_idx), 32'd1);
    frame_count = 4'd6;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("fcchg%0d.idx", i),  32'(frame_idx), 32'((i % 3) + 1));
      chk($sformatf("fcchg%0d.wrap", i), 32'(wrap),      32'((i % 3) == 0));
    end

    // Randomized run against the reference model
    for (int i = 0; i < 800; i++) begin
      Reset_n     = ($urandom_range(49) != 0);
      tick        = 1'($urandom_range(1));
      moving      = ($urandom_range(9) != 0);
      mode        = 2'($urandom_range(3));
      frame_count = 4'($urandom_range(15));
      hold        = 4'($urandom_range(3));
      if ($urandom_range(7) == 0) begin
        sprite_height = 10'($urandom);
        sprite_width  = 10'($urandom);
      end
      base_offset = $urandom;
      step();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_sequencer.md
SPRITE_SEQUENCER -- requirements
Module: sprite_sequencer

Interface
REQ-001 Parameter NUM_FRAMES, default 8, SHALL set the maximum number of run frames (1..15).
REQ-002 Parameter HOLD_W, default 4, SHALL set the width of the per-frame hold count.
REQ-003 Parameter DIM_W, default 10, SHALL set the width of the sprite dimensions.
REQ-004 Parameter OFS_W, default 32, SHALL set the width of the offsets.
REQ-005 Port Clk, in, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port Reset_n, in, 1: the reset, synchronous and active-low.
REQ-007 Port tick, in, 1: the advance strobe, one Clk cycle per display frame.
REQ-008 Port moving, in, 1: the run request level.
REQ-009 Port mode, in, 2: 00 loop, 01 ping-pong, 10 one-shot; 11 SHALL behave as loop.
REQ-010 Port frame_count, in, FC_W=$clog2(NUM_FRAMES+1): the number of run frames N.
REQ-011 Port hold, in, HOLD_W: each frame SHALL be held for hold+1 ticks.
REQ-012 Ports sprite_height and sprite_width, in, DIM_W: the sprite dimensions in pixels.
REQ-013 Port base_offset, in, OFS_W: the address of frame 0 (the idle pose).
REQ-014 Port animation_offset, out, OFS_W, registered: the sprite ROM offset.
REQ-015 Port frame_idx, out, FC_W, registered: the current frame, 0 = idle.
REQ-016 Port done, out, 1: high while in the DONE state.
REQ-017 Port wrap, out, 1: a one-cycle pulse on sequence wrap.

Function
REQ-018 States SHALL be IDLE, RUN and DONE; transitions SHALL occur only on edges where tick=1, except reset.
REQ-019 IDLE: frame_idx=0, hold_cnt=0; tick with moving=1 -> RUN.
REQ-020 On IDLE->RUN the block SHALL latch mode, N and hold, and set frame_idx=1, hold_cnt=0, dir=up.
REQ-021 Latched N SHALL be clamped: 0 -> 1; values above NUM_FRAMES -> NUM_FRAMES.
REQ-022 Changes to mode, frame_count or hold during RUN or DONE SHALL be ignored until the next IDLE->RUN.
REQ-023 RUN, tick with moving=0 -> IDLE, frame_idx=0, hold_cnt=0; this takes priority over advancing.
REQ-024 RUN, tick with moving=1 and hold_cnt<hold: hold_cnt SHALL increment and frame_idx SHALL be held.
REQ-025 RUN, tick with moving=1 and hold_cnt==hold: hold_cnt SHALL clear and frame_idx SHALL advance per REQ-026 to REQ-028.
REQ-026 Loop: idx<N -> idx+1; idx==N -> 1 with wrap pulse (N=1 stays at 1 and pulses wrap).
REQ-027 Ping-pong: when up, idx<N -> idx+1, and idx==N -> N-1 with dir=down; when down, idx>1 -> idx-1, and idx==1 -> 2 with dir=up and wrap pulse; N=1 SHALL stay at 1 with a wrap pulse each advance; N=2 SHALL alternate 1,2,1,2.
REQ-028 One-shot: idx<N -> idx+1; idx==N -> DONE with frame_idx kept at N.
REQ-029 DONE: done=1 and frame_idx=N; tick with moving=0 -> IDLE; tick with moving=1 -> stay in DONE.
REQ-030 wrap SHALL be high for exactly the one Clk cycle following the advancing edge, and 0 otherwise.
REQ-031 animation_offset SHALL equal base_offset + frame_idx*sprite_height*sprite_width, truncated to OFS_W, using live dimension and base inputs.
REQ-032 animation_offset SHALL be registered one Clk after frame_idx, giving a latency of 1 Clk behind frame_idx.
REQ-033 The product SHALL be computed at full width (FC_W+2*DIM_W) before truncation.
REQ-034 When tick=0 no state, counter or index SHALL change; only animation_offset tracks its inputs.

Reset
REQ-035 Reset_n=0 at a Clk edge SHALL, regardless of tick, set state=IDLE, frame_idx=0, hold_cnt=0, dir=up, done=0, wrap=0 and animation_offset=0.
REQ-036 The first edge after Reset_n returns high SHALL load animation_offset=base_offset.
REQ-037 Reset asserted mid-RUN or in DONE SHALL abort with no wrap or done pulse.

Verification
REQ-038 With h=w=10, base=0, loop, N=3, hold=0, moving=1 and 5 ticks: frame_idx SHALL go 1,2,3,1,2; offsets SHALL be 100,200,300,100,200; wrap SHALL fire once after the 4th tick.
REQ-039 With ping-pong, N=5, hold=3 and 40 ticks: frame_idx SHALL be 1,2,3,4,5,4,3,2,1,2, each held 4 ticks; wrap SHALL fire on the 1->2 transition only.
REQ-040 With one-shot, N=2, hold=1: frame_idx SHALL be 1,1,2,2 then DONE with idx 2 and done=1 held; then moving=0 plus a tick SHALL give idx 0, done=0 and offset=base.
REQ-041 With moving dropped during a hold (loop, N=4, hold=7, idx=3, hold_cnt=2): the next tick SHALL give IDLE with idx 0; re-asserting moving SHALL restart at idx 1 with a fresh hold.
REQ-042 Pulling Reset_n low mid-RUN with tick=0 SHALL zero all outputs on the next edge; with frame_count=0 latched, the sequence SHALL remain at idx 1 and wrap SHALL pulse each advance.
REQ-043 Changing frame_count from 3 to 6 mid-RUN SHALL leave the wrap at 3 until the next IDLE->RUN.
